// File: rtl/apb_reset_pkg.sv
// Shared types and constants for the APB reset controller.
// Holds the sequencer state encoding and the reset-cause codes.
package apb_reset_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } rst_state_e;

  localparam logic [1:0] RST_CAUSE_PIN = 2'b01;
  localparam logic [1:0] RST_CAUSE_SW  = 2'b10;

endpackage

// File: rtl/reset_sync.sv
// Release synchronizer for an asynchronous active-low reset.
// Assertion clears the chain immediately; release ripples a constant 1 through it.
module reset_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] chain_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/apb_reset_ctrl.sv
// Reset sequencer: synchronizes pin release, holds, then releases N_OUT domains
// in staggered order; also runs software-requested reset sequences with an ack.
module apb_reset_ctrl
  import apb_reset_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int N_OUT       = 2,
  parameter int STAGGER     = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sw_rst_req,
  output logic             sw_rst_ack,
  output logic [N_OUT-1:0] rst_out_n,
  output logic             rst_busy,
  output logic [1:0]       rst_cause
);

  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("apb_reset_ctrl: SYNC_STAGES must be >= 2");
  end
  if (HOLD_CYCLES < 1) begin : g_chk_hold
    $error("apb_reset_ctrl: HOLD_CYCLES must be >= 1");
  end
  if (N_OUT < 1) begin : g_chk_nout
    $error("apb_reset_ctrl: N_OUT must be >= 1");
  end
  if (STAGGER < 1) begin : g_chk_stagger
    $error("apb_reset_ctrl: STAGGER must be >= 1");
  end
  if ((longint'(HOLD_CYCLES) - 1 > (longint'(1) << CNT_W) - 1) ||
      (longint'(N_OUT - 1) * STAGGER > (longint'(1) << CNT_W) - 1)) begin : g_chk_cnt
    $error("apb_reset_ctrl: CNT_W too narrow for HOLD_CYCLES/STAGGER");
  end

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  // With N_OUT == 1 this wraps to all ones, but RELEASE is then unreachable.
  localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'((N_OUT - 1) * STAGGER - 1);

  rst_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N_OUT-1:0] rst_out_q;
  logic             busy_q;
  logic             ack_q;
  logic [1:0]       cause_q;
  logic             pin_released;

  reset_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_reset_sync (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .sync_o (pin_released)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ASSERT;
      cnt_q     <= '0;
      rst_out_q <= '0;
      busy_q    <= 1'b1;
      ack_q     <= 1'b0;
      cause_q   <= RST_CAUSE_PIN;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        ASSERT: begin
          if (pin_released) begin
            state_q <= HOLD;
            cnt_q   <= '0;
          end
        end
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            rst_out_q[0] <= 1'b1;
            cnt_q        <= '0;
            if (N_OUT == 1) begin
              state_q <= RUN;
              busy_q  <= 1'b0;
              ack_q   <= (cause_q == RST_CAUSE_SW);
            end else begin
              state_q <= RELEASE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RELEASE: begin
          cnt_q <= cnt_q + 1'b1;
          for (int i = 1; i < N_OUT; i++) begin
            if (cnt_q == CNT_W'(i * STAGGER - 1)) begin
              rst_out_q[i] <= 1'b1;
            end
          end
          if (cnt_q == REL_LAST) begin
            state_q <= RUN;
            busy_q  <= 1'b0;
            ack_q   <= (cause_q == RST_CAUSE_SW);
          end
        end
        RUN: begin
          // The ack cycle masks the request so a requester has one cycle to drop it.
          if (sw_rst_req && !ack_q) begin
            state_q   <= HOLD;
            cnt_q     <= '0;
            rst_out_q <= '0;
            busy_q    <= 1'b1;
            cause_q   <= RST_CAUSE_SW;
          end
        end
        default: begin
          state_q <= ASSERT;
        end
      endcase
    end
  end

  assign rst_out_n  = rst_out_q;
  assign rst_busy   = busy_q;
  assign sw_rst_ack = ack_q;
  assign rst_cause  = cause_q;

endmodule
